// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares one write-through memory request channel between the
// icache miss unit (port 0, reads only) and the dcache miss/write-buffer unit
// (port 1, reads and writes).
//
// Arbitration is round-robin. When the downstream applies backpressure, the
// grant and its payload are held in a register until the handshake completes.
// The downstream tag is {source, local tid}, and returns are routed back by
// the top bit of that tag. Each source has an in-flight counter that caps
// issue. Port-1 stores have an additional in-flight cap.
//
// Optional feature: define MEM_ARB_PERF_EN to add ic_stall_cnt_o and
// dc_stall_cnt_o. Each is a saturating count of the cycles in which its port
// had valid high and ready low.
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   ic_req_valid_i/ready_o        icache request handshake
//   ic_req_addr_i/tid_i           icache address and local id
//   dc_req_valid_i/ready_o        dcache request handshake
//   dc_req_we_i/addr_i/wdata_i    dcache write flag, address and write data
//   dc_req_tid_i                  dcache local id
//   mem_req_valid_o/ready_i       downstream request handshake
//   mem_req_we_o/addr_o/wdata_o   downstream payload
//   mem_req_tid_o                 {source, local tid}
//   mem_rtrn_valid_i/tid_i        downstream return (no backpressure)
//   ic_rtrn_valid_o               return belongs to the icache
//   dc_rtrn_valid_o               return belongs to the dcache
//   rtrn_tid_o                    local tid of the current return
//   idle_o                        nothing outstanding on either source
//   err_o                         sticky: return for a source with nothing outstanding
module mem_req_arbiter #(
  parameter int unsigned TidWidth             = 2,
  parameter int unsigned AddrWidth            = 64,
  parameter int unsigned DataWidth            = 64,
  parameter int unsigned MaxOutstanding       = 4,
  parameter int unsigned MaxOutstandingStores = 7
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ic_req_valid_i,
  output logic                 ic_req_ready_o,
  input  logic [AddrWidth-1:0] ic_req_addr_i,
  input  logic [TidWidth-1:0]  ic_req_tid_i,
  output logic                 ic_rtrn_valid_o,
  input  logic                 dc_req_valid_i,
  output logic                 dc_req_ready_o,
  input  logic                 dc_req_we_i,
  input  logic [AddrWidth-1:0] dc_req_addr_i,
  input  logic [DataWidth-1:0] dc_req_wdata_i,
  input  logic [TidWidth-1:0]  dc_req_tid_i,
  output logic                 dc_rtrn_valid_o,
  output logic                 mem_req_valid_o,
  input  logic                 mem_req_ready_i,
  output logic                 mem_req_we_o,
  output logic [AddrWidth-1:0] mem_req_addr_o,
  output logic [DataWidth-1:0] mem_req_wdata_o,
  output logic [TidWidth:0]    mem_req_tid_o,
  input  logic                 mem_rtrn_valid_i,
  input  logic [TidWidth:0]    mem_rtrn_tid_i,
  output logic [TidWidth-1:0]  rtrn_tid_o,
  output logic                 idle_o,
`ifdef MEM_ARB_PERF_EN
  output logic [31:0]          ic_stall_cnt_o,
  output logic [31:0]          dc_stall_cnt_o,
`endif
  output logic                 err_o
);

  localparam int unsigned CntWidth   = $clog2(MaxOutstanding + 1);
  localparam int unsigned StCntWidth = $clog2(MaxOutstandingStores + 1);
  localparam int unsigned NumTids    = 1 << TidWidth;

  typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

  typedef struct packed {
    logic                 src;
    logic                 we;
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] wdata;
    logic [TidWidth-1:0]  tid;
  } req_t;

  state_e                state_q;
  req_t                  hold_q;
  logic                  rr_q;
  logic [CntWidth-1:0]   cnt0_q, cnt1_q, cnt0_d, cnt1_d;
  logic [StCntWidth-1:0] st_cnt_q, st_cnt_d;
  logic [NumTids-1:0]    we_tbl_q;

  req_t sel_c, out_c;
  logic elig0_c, elig1_c, pick1_c, arb_valid_c, out_valid_c, accept_c;
  logic iss0_c, iss1_c, st_iss_c, ret0_c, ret1_c, st_ret_c;

  // Eligibility and round-robin pick (rr_q = 0 favours port 0)
  always_comb begin
    elig0_c     = ic_req_valid_i && (cnt0_q < CntWidth'(MaxOutstanding));
    elig1_c     = dc_req_valid_i && (cnt1_q < CntWidth'(MaxOutstanding)) &&
                  (!dc_req_we_i || (st_cnt_q < StCntWidth'(MaxOutstandingStores)));
    pick1_c     = elig1_c && (!elig0_c || rr_q);
    arb_valid_c = elig0_c || elig1_c;
  end

  // Payload of the freshly arbitrated port
  always_comb begin
    sel_c = '0;
    if (pick1_c) begin
      sel_c.src   = 1'b1;
      sel_c.we    = dc_req_we_i;
      sel_c.addr  = dc_req_addr_i;
      sel_c.wdata = dc_req_wdata_i;
      sel_c.tid   = dc_req_tid_i;
    end else begin
      sel_c.addr  = ic_req_addr_i;
      sel_c.tid   = ic_req_tid_i;
    end
  end

  // While locked, the held payload drives the channel; otherwise the pick
  // passes through combinationally for zero-latency issue.
  always_comb begin
    out_c       = (state_q == ST_LOCKED) ? hold_q : sel_c;
    out_valid_c = !rst_i && ((state_q == ST_LOCKED) || arb_valid_c);
    accept_c    = out_valid_c && mem_req_ready_i;
  end

  assign mem_req_valid_o = out_valid_c;
  assign mem_req_we_o    = out_c.we;
  assign mem_req_addr_o  = out_c.addr;
  assign mem_req_wdata_o = out_c.wdata;
  assign mem_req_tid_o   = {out_c.src, out_c.tid};
  assign ic_req_ready_o  = accept_c && !out_c.src;
  assign dc_req_ready_o  = accept_c && out_c.src;

  // Return routing by the source bit of the tag
  assign ic_rtrn_valid_o = !rst_i && mem_rtrn_valid_i && !mem_rtrn_tid_i[TidWidth];
  assign dc_rtrn_valid_o = !rst_i && mem_rtrn_valid_i &&  mem_rtrn_tid_i[TidWidth];
  assign rtrn_tid_o      = mem_rtrn_tid_i[TidWidth-1:0];

  // Issue/return events feeding the counters
  always_comb begin
    iss0_c   = accept_c && !out_c.src;
    iss1_c   = accept_c &&  out_c.src;
    st_iss_c = iss1_c && out_c.we;
    ret0_c   = mem_rtrn_valid_i && !mem_rtrn_tid_i[TidWidth];
    ret1_c   = mem_rtrn_valid_i &&  mem_rtrn_tid_i[TidWidth];
    st_ret_c = ret1_c && we_tbl_q[mem_rtrn_tid_i[TidWidth-1:0]];
  end

  // Counter next state: simultaneous issue and return cancel out; decrements
  // saturate at zero. Increments cannot overflow because eligibility blocks
  // issue at the cap.
  always_comb begin
    cnt0_d   = cnt0_q;
    cnt1_d   = cnt1_q;
    st_cnt_d = st_cnt_q;
    if (iss0_c && !ret0_c) begin
      cnt0_d = cnt0_q + CntWidth'(1);
    end else if (ret0_c && !iss0_c && (cnt0_q != '0)) begin
      cnt0_d = cnt0_q - CntWidth'(1);
    end
    if (iss1_c && !ret1_c) begin
      cnt1_d = cnt1_q + CntWidth'(1);
    end else if (ret1_c && !iss1_c && (cnt1_q != '0)) begin
      cnt1_d = cnt1_q - CntWidth'(1);
    end
    if (st_iss_c && !st_ret_c) begin
      st_cnt_d = st_cnt_q + StCntWidth'(1);
    end else if (st_ret_c && !st_iss_c && (st_cnt_q != '0)) begin
      st_cnt_d = st_cnt_q - StCntWidth'(1);
    end
  end

  // Lock FSM, round-robin pointer, in-flight bookkeeping and status flags
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      hold_q   <= '0;
      rr_q     <= 1'b0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
      st_cnt_q <= '0;
      we_tbl_q <= '0;
      err_o    <= 1'b0;
      idle_o   <= 1'b1;
    end else begin
      if (state_q == ST_IDLE) begin
        if (arb_valid_c && !mem_req_ready_i) begin
          state_q <= ST_LOCKED;
          hold_q  <= sel_c;
        end
      end else if (mem_req_ready_i) begin
        state_q <= ST_IDLE;
      end
      if (accept_c) begin
        rr_q <= ~out_c.src;
      end
      // Write flag is remembered per dcache local tid so the return knows
      // whether it acknowledges a store.
      if (iss1_c) begin
        we_tbl_q[out_c.tid] <= out_c.we;
      end
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
      st_cnt_q <= st_cnt_d;
      err_o    <= err_o || (ret0_c && (cnt0_q == '0)) || (ret1_c && (cnt1_q == '0));
      idle_o   <= (cnt0_d == '0) && (cnt1_d == '0);
    end
  end

`ifdef MEM_ARB_PERF_EN
  // Saturating wait-cycle counters per port
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ic_stall_cnt_o <= '0;
      dc_stall_cnt_o <= '0;
    end else begin
      if (ic_req_valid_i && !ic_req_ready_o && (ic_stall_cnt_o != '1)) begin
        ic_stall_cnt_o <= ic_stall_cnt_o + 32'd1;
      end
      if (dc_req_valid_i && !dc_req_ready_o && (dc_stall_cnt_o != '1)) begin
        dc_stall_cnt_o <= dc_stall_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Testbench for mem_req_arbiter: directed scenarios followed by randomized
// traffic, all checked every cycle against a queue-based reference model.
module tb_mem_req_arbiter;

  localparam int TW = 2;
  localparam int MO = 4;
  // Store cap set below the per-source cap so that it can actually bind.
  localparam int MS = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          ic_v, dc_v, dc_we, mem_ready, rtrn_v;
  logic [63:0]   ic_addr, dc_addr, dc_wdata;
  logic [TW-1:0] ic_tid, dc_tid;
  logic [TW:0]   rtrn_tid;

  logic          ic_ready, dc_ready, ic_rtrn, dc_rtrn, mem_valid, mem_we, idle, err;
  logic [63:0]   mem_addr, mem_wdata;
  logic [TW:0]   mem_tid;
  logic [TW-1:0] r_tid;
`ifdef MEM_ARB_PERF_EN
  logic [31:0]   ic_stall, dc_stall;
`endif

  mem_req_arbiter #(
    .TidWidth(TW), .AddrWidth(64), .DataWidth(64),
    .MaxOutstanding(MO), .MaxOutstandingStores(MS)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .ic_req_valid_i(ic_v), .ic_req_ready_o(ic_ready),
    .ic_req_addr_i(ic_addr), .ic_req_tid_i(ic_tid),
    .ic_rtrn_valid_o(ic_rtrn),
    .dc_req_valid_i(dc_v), .dc_req_ready_o(dc_ready),
    .dc_req_we_i(dc_we), .dc_req_addr_i(dc_addr),
    .dc_req_wdata_i(dc_wdata), .dc_req_tid_i(dc_tid),
    .dc_rtrn_valid_o(dc_rtrn),
    .mem_req_valid_o(mem_valid), .mem_req_ready_i(mem_ready),
    .mem_req_we_o(mem_we), .mem_req_addr_o(mem_addr),
    .mem_req_wdata_o(mem_wdata), .mem_req_tid_o(mem_tid),
    .mem_rtrn_valid_i(rtrn_v), .mem_rtrn_tid_i(rtrn_tid),
    .rtrn_tid_o(r_tid), .idle_o(idle),
`ifdef MEM_ARB_PERF_EN
    .ic_stall_cnt_o(ic_stall), .dc_stall_cnt_o(dc_stall),
`endif
    .err_o(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int src; int tid; bit we; } flight_t;
  typedef struct {
    bit v; int src; bit we; logic [63:0] addr; logic [63:0] wdata; int tid;
  } mreq_t;

  flight_t q[$];         // accepted, not yet returned
  mreq_t   m_hold;
  bit      m_locked = 0;
  int      m_pref   = 0; // port favoured when both are eligible
  bit      m_err    = 0;
  bit      m_acc0   = 0;
  bit      m_acc1   = 0;

  function automatic int n_src(input int s);
    int n = 0;
    foreach (q[i]) if (q[i].src == s) n++;
    return n;
  endfunction

  function automatic int n_st();
    int n = 0;
    foreach (q[i]) if (q[i].src == 1 && q[i].we) n++;
    return n;
  endfunction

  function automatic bit in_flight(input int s, input int t);
    foreach (q[i]) if (q[i].src == s && q[i].tid == t) return 1;
    return 0;
  endfunction

  function automatic int free_tid(input int s);
    int start = int'($urandom_range(0, (1 << TW) - 1));
    for (int k = 0; k < (1 << TW); k++) begin
      int t = (start + k) % (1 << TW);
      if (!in_flight(s, t)) return t;
    end
    return -1;
  endfunction

  // What the channel should present this cycle, from the model state and inputs
  function automatic mreq_t arb();
    mreq_t r;
    bit e0, e1;
    r.v = 0; r.src = 0; r.we = 0; r.addr = '0; r.wdata = '0; r.tid = 0;
    if (m_locked) return m_hold;
    e0 = ic_v && (n_src(0) < MO);
    e1 = dc_v && (n_src(1) < MO) && (!dc_we || (n_st() < MS));
    if (!e0 && !e1) return r;
    r.v   = 1;
    r.src = (e0 && e1) ? m_pref : (e1 ? 1 : 0);
    if (r.src == 1) begin
      r.we = dc_we; r.addr = dc_addr; r.wdata = dc_wdata; r.tid = int'(dc_tid);
    end else begin
      r.addr = ic_addr; r.tid = int'(ic_tid);
    end
    return r;
  endfunction

  // Model update on each rising edge
  initial forever begin : model
    mreq_t e;
    int s, t, idx;
    @(posedge clk);
    m_acc0 = 0;
    m_acc1 = 0;
    if (rst) begin
      q.delete();
      m_locked = 0;
      m_pref   = 0;
      m_err    = 0;
    end else begin
      e = arb();
      if (rtrn_v) begin
        s = int'(rtrn_tid[TW]);
        t = int'(rtrn_tid[TW-1:0]);
        idx = -1;
        foreach (q[i]) if (idx < 0 && q[i].src == s && q[i].tid == t) idx = i;
        if (idx >= 0) q.delete(idx);
        else m_err = 1;
      end
      if (e.v) begin
        if (mem_ready) begin
          q.push_back('{src: e.src, tid: e.tid, we: e.we});
          m_pref   = 1 - e.src;
          m_locked = 0;
          if (e.src == 0) m_acc0 = 1; else m_acc1 = 1;
        end else begin
          m_locked = 1;
          m_hold   = e;
        end
      end
    end
  end

  // Compare every cycle on the falling edge
  initial forever begin : cmp
    mreq_t e;
    @(negedge clk);
    e = arb();
    if (rst) e.v = 0;
    check("mem_valid", 64'(mem_valid), 64'(e.v));
    if (e.v) begin
      check("mem_addr", mem_addr, e.addr);
      check("mem_we", 64'(mem_we), 64'(e.we));
      check("mem_tid", 64'(mem_tid), 64'(e.src * (1 << TW) + e.tid));
      if (e.we) check("mem_wdata", mem_wdata, e.wdata);
    end
    check("ic_ready", 64'(ic_ready), 64'(e.v && mem_ready && e.src == 0));
    check("dc_ready", 64'(dc_ready), 64'(e.v && mem_ready && e.src == 1));
    check("ic_rtrn", 64'(ic_rtrn), 64'(!rst && rtrn_v && !rtrn_tid[TW]));
    check("dc_rtrn", 64'(dc_rtrn), 64'(!rst && rtrn_v && rtrn_tid[TW]));
    if (rtrn_v) check("rtrn_tid", 64'(r_tid), 64'(rtrn_tid[TW-1:0]));
    check("idle", 64'(idle), rst ? 64'd1 : 64'(q.size() == 0));
    check("err", 64'(err), rst ? 64'd0 : 64'(m_err));
  end

  // ---------------- stimulus ----------------
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic ret(input logic [TW:0] tag);
    rtrn_v = 1'b1;
    rtrn_tid = tag;
    neg();
    nxt();
    rtrn_v = 1'b0;
  endtask

  initial begin
    int t;
    bit ic_pend, dc_pend;
    rst = 1'b1;
    ic_v = 0; dc_v = 0; dc_we = 0; mem_ready = 0; rtrn_v = 0;
    ic_addr = '0; dc_addr = '0; dc_wdata = '0; ic_tid = '0; dc_tid = '0; rtrn_tid = '0;

    // Reset state
    neg();
    check("rst_valid", 64'(mem_valid), 64'd0);
    check("rst_ic_ready", 64'(ic_ready), 64'd0);
    check("rst_dc_ready", 64'(dc_ready), 64'd0);
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_err", 64'(err), 64'd0);
    nxt();
    rst = 1'b0;

    // Alternating grants, each port stops at its outstanding cap
    ic_v = 1; dc_v = 1; dc_we = 0; mem_ready = 1;
    for (int i = 0; i < 10; i++) begin
      ic_addr = 64'h1000 + 64'(i);
      dc_addr = 64'h2000 + 64'(i);
      neg();
      check("alt_ic", 64'(ic_ready), 64'(i < 8 && i % 2 == 0));
      check("alt_dc", 64'(dc_ready), 64'(i < 8 && i % 2 == 1));
      nxt();
      if (m_acc0) ic_tid = TW'(ic_tid + 1);
      if (m_acc1) dc_tid = TW'(dc_tid + 1);
    end
    ic_v = 0; dc_v = 0;
    for (int k = 0; k < 8; k++) begin
      rtrn_v = 1;
      rtrn_tid = (TW + 1)'((k / 4) * 4 + (k % 4));
      neg();
      if (k == 2) begin
        check("rt_ic_valid", 64'(ic_rtrn), 64'd1);
        check("rt_dc_valid", 64'(dc_rtrn), 64'd0);
        check("rt_tid", 64'(r_tid), 64'h2);
      end
      nxt();
    end
    rtrn_v = 0;
    neg();
    check("drain_idle", 64'(idle), 64'd1);
    nxt();

    // Grant lock under backpressure; held payload survives input changes
    dc_v = 1; dc_we = 0; dc_addr = 64'h8000_0040; dc_tid = 2'd1; mem_ready = 0;
    neg();
    check("lock_addr0", mem_addr, 64'h8000_0040);
    nxt();
    ic_v = 1; ic_addr = 64'h3000; ic_tid = 2'd0; dc_addr = 64'hdead_beef;
    for (int i = 0; i < 4; i++) begin
      neg();
      check("lock_addr", mem_addr, 64'h8000_0040);
      check("lock_src", 64'(mem_tid[TW]), 64'd1);
      check("lock_ic_wait", 64'(ic_ready), 64'd0);
      nxt();
    end
    mem_ready = 1;
    neg();
    check("lock_dc_acc", 64'(dc_ready), 64'd1);
    nxt();
    dc_v = 0;
    neg();
    check("after_lock_ic", 64'(ic_ready), 64'd1);
    check("after_lock_src", 64'(mem_tid[TW]), 64'd0);
    nxt();
    ic_v = 0;
    ret(3'b101);
    ret(3'b000);

    // Store cap: MS writes issue, the next one waits for a write ack
    dc_v = 1; dc_we = 1; dc_tid = '0;
    for (int i = 0; i < 5; i++) begin
      dc_wdata = 64'hA5A5_0000 + 64'(i);
      neg();
      check("st_cap", 64'(dc_ready), 64'(i < MS));
      nxt();
      if (m_acc1) dc_tid = TW'(dc_tid + 1);
    end
    rtrn_v = 1; rtrn_tid = 3'b100;
    neg();
    check("st_cap_ack_cyc", 64'(dc_ready), 64'd0);
    nxt();
    rtrn_v = 0;
    neg();
    check("st_after_ack", 64'(dc_ready), 64'd1);
    nxt();
    dc_v = 0; dc_we = 0;
    ret(3'b101);
    ret(3'b110);
    ret(3'b111);

    // Simultaneous issue and return on port 1 leave its count unchanged
    dc_v = 1; dc_we = 0; dc_tid = 2'd0;
    neg(); nxt();
    dc_tid = 2'd1;
    neg(); nxt();
    dc_tid = 2'd2; rtrn_v = 1; rtrn_tid = 3'b100;
    neg();
    check("simul_acc", 64'(dc_ready), 64'd1);
    nxt();
    dc_v = 0;
    ret(3'b101);
    rtrn_v = 1; rtrn_tid = 3'b110;
    neg();
    check("simul_not_idle", 64'(idle), 64'd0);
    nxt();
    rtrn_v = 0;
    neg();
    check("simul_idle", 64'(idle), 64'd1);
    nxt();

    // Return to a source with nothing outstanding sets a sticky error
    ret(3'b000);
    neg();
    check("err_set", 64'(err), 64'd1);
    check("err_idle", 64'(idle), 64'd1);
    nxt(); nxt(); nxt();
    neg();
    check("err_sticky", 64'(err), 64'd1);
    nxt();

    // Reset while locked with three dcache reads in flight
    dc_v = 1; dc_we = 0; mem_ready = 1;
    for (int i = 0; i < 3; i++) begin
      dc_tid = TW'(i);
      neg(); nxt();
    end
    dc_tid = 2'd3; mem_ready = 0;
    neg();
    check("prerst_valid", 64'(mem_valid), 64'd1);
    nxt();
    rst = 1; dc_v = 0;
    neg();
    check("inrst_valid", 64'(mem_valid), 64'd0);
    nxt(); nxt();
    rst = 0;
    neg();
    check("postrst_valid", 64'(mem_valid), 64'd0);
    check("postrst_idle", 64'(idle), 64'd1);
    check("postrst_err", 64'(err), 64'd0);
    nxt();

    // Randomized traffic with protocol-compliant requesters
    ic_pend = 0; dc_pend = 0;
    for (int c = 0; c < 3000; c++) begin
      if (m_acc0) ic_pend = 0;
      if (m_acc1) dc_pend = 0;
      if (!ic_pend && $urandom_range(0, 2) != 0) begin
        t = free_tid(0);
        if (t >= 0) begin
          ic_pend = 1; ic_tid = TW'(t); ic_addr = {$urandom, $urandom};
        end
      end
      if (!dc_pend && $urandom_range(0, 2) != 0) begin
        t = free_tid(1);
        if (t >= 0) begin
          dc_pend = 1; dc_tid = TW'(t); dc_we = 1'($urandom_range(0, 1));
          dc_addr = {$urandom, $urandom}; dc_wdata = {$urandom, $urandom};
        end
      end
      ic_v = ic_pend;
      dc_v = dc_pend;
      mem_ready = ($urandom_range(0, 3) != 0);
      if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
        t = int'($urandom_range(0, q.size() - 1));
        rtrn_v = 1;
        rtrn_tid = (TW + 1)'(q[t].src * (1 << TW) + q[t].tid);
      end else begin
        rtrn_v = 0;
      end
      nxt();
    end
    ic_v = 0; dc_v = 0; rtrn_v = 0;
    neg();
    nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
